// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues single-byte I2C read/write commands and runs them
// one at a time against the downstream I2C master, returning one response each.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,     // power of two, >= 2
    parameter int IDLE_GAP   = 15,    // >= 1
    parameter int TIMEOUT    = 4096   // >= 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic [6:0] address,
    output logic       m_rw,
    output logic [7:0] m_tx_data,
    output logic       m_enable,
    input  logic       m_ack,
    input  logic       m_nack,
    input  logic       m_ready,
    input  logic [7:0] m_rx_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_rw,
    output logic [6:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_READY,
        ST_RESP,
        ST_GAP
    } state_t;

    state_t        state;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ack_seen;
    logic          nack_flag;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic          to_hit;

    assign empty     = (count == '0);
    assign cmd_ready = (count != DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !empty;
    assign busy      = (state != ST_IDLE) || !empty;
    // Abort applies to both phases where the master owns the transaction.
    assign to_hit    = ((state == ST_ISSUE) || (state == ST_WAIT_READY)) && (to_cnt == TO_LAST);

    // Command storage; entries are {rw, addr, data}. No reset needed, count guards reads.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Transaction sequencer; the master-facing command outputs double as the
    // current-command registers and only change on a pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            address     <= '0;
            m_rw        <= 1'b0;
            m_tx_data   <= '0;
            m_enable    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rw      <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            ack_seen    <= 1'b0;
            nack_flag   <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else if (to_hit) begin
            m_enable    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rw      <= m_rw;
            rsp_addr    <= address;
            rsp_data    <= '0;
            rsp_nack    <= nack_flag;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        {m_rw, address, m_tx_data} <= fifo_mem[rd_ptr];
                        ack_seen  <= 1'b0;
                        nack_flag <= 1'b0;
                        to_cnt    <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt   <= to_cnt + 1'b1;
                    m_enable <= 1'b1;
                    if (m_ack) ack_seen <= 1'b1;
                    // A nack outranks a simultaneous end of the ack phase.
                    if (m_nack) begin
                        nack_flag <= 1'b1;
                        m_enable  <= 1'b0;
                        state     <= ST_WAIT_READY;
                    end else if (ack_seen && !m_ack) begin
                        m_enable <= 1'b0;
                        state    <= ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (m_ready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rw      <= m_rw;
                        rsp_addr    <= address;
                        rsp_data    <= m_rw ? m_rx_data : 8'h00;
                        rsp_nack    <= nack_flag;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed testbench for i2c_cmd_sequencer with a small behavioural I2C master.
module tb_i2c_cmd_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int IDLE_GAP   = 15;
    localparam int TIMEOUT    = 4096;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic [6:0] address;
    logic       m_rw;
    logic [7:0] m_tx_data;
    logic       m_enable;
    logic       m_ack = 1'b0;
    logic       m_nack = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_rx_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_rw;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    i2c_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .address(address), .m_rw(m_rw), .m_tx_data(m_tx_data), .m_enable(m_enable),
        .m_ack(m_ack), .m_nack(m_nack), .m_ready(m_ready), .m_rx_data(m_rx_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural master: mode 0 acks, mode 1 nacks, mode 2 never responds.
    typedef enum {MI, ME, MN, MW, MR, MD} mst_t;
    mst_t       ms = MI;
    int         mcnt = 0;
    int         mode = 0;
    int         en_cycles = 0;
    logic [7:0] rx_byte = '0;
    logic       cap_rw = 1'b0;
    logic [6:0] cap_addr = '0;
    logic [7:0] cap_data = '0;

    always @(negedge clock) begin
        if (!reset) begin
            ms = MI; m_ack = 0; m_nack = 0; m_ready = 0; m_rx_data = '0;
        end else begin
            if (m_enable) en_cycles++;
            case (ms)
                MI: if (m_enable) begin
                    cap_rw = m_rw; cap_addr = address; cap_data = m_tx_data;
                    mcnt = 0; ms = ME;
                end
                ME: begin
                    mcnt++;
                    if (mode == 2) begin
                        if (!m_enable) ms = MI;
                    end else if (mode == 1) begin
                        if (mcnt == 2) begin m_nack = 1; ms = MN; end
                    end else begin
                        if (mcnt == 2) m_ack = 1;
                        if (mcnt == 4) begin m_ack = 0; ms = MW; end
                    end
                end
                MN: begin m_nack = 0; ms = MW; end
                MW: if (!m_enable) begin mcnt = 0; ms = MR; end
                MR: begin
                    mcnt++;
                    if (mcnt == 2) begin m_ready = 1; m_rx_data = rx_byte; ms = MD; end
                end
                MD: begin m_ready = 0; m_rx_data = '0; ms = MI; end
                default: ms = MI;
            endcase
        end
    end

    function automatic logic [37:0] out_vec();
        return {cmd_ready, address, m_rw, m_tx_data, m_enable, rsp_valid,
                rsp_rw, rsp_addr, rsp_data, rsp_nack, rsp_timeout, busy};
    endfunction

    function automatic logic [17:0] rsp_vec();
        return {rsp_rw, rsp_addr, rsp_data, rsp_nack, rsp_timeout};
    endfunction

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && n < 500) begin @(negedge clock); n++; end
        ok = cmd_ready;
        if (ok) @(posedge clock);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        int n = 0;
        while (!rsp_valid && n < limit) begin @(negedge clock); n++; end
        ok = rsp_valid;
    endtask

    task automatic ack_rsp();
        @(negedge clock);
        rsp_ready = 1;
        @(posedge clock);
        #1 rsp_ready = 0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 200) begin @(negedge clock); n++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        logic [37:0] exp_v;
        exp_v = {1'b1, 37'd0};
        #2;
        checks++;
        if (out_vec() !== exp_v) begin errors++; $display("FAIL reset_during: got %h expected %h", out_vec(), exp_v); end
        repeat (3) @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);
        checks++;
        if (out_vec() !== exp_v) begin errors++; $display("FAIL reset_after: got %h expected %h", out_vec(), exp_v); end
    endtask

    task automatic test_write();
        bit ok;
        int n;
        mode = 0; en_cycles = 0;
        push(1'b0, 7'h50, 8'hFE, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept: got 0 expected 1"); end
        n = 0;
        while (!m_enable && n < 20) begin @(posedge clock); #1; n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL issue_latency: got %0d expected 2", n); end
        wait_rsp(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_rsp_wait: got no response expected response"); end
        checks++;
        if ({cap_rw, cap_addr, cap_data} !== {1'b0, 7'h50, 8'hFE})
            begin errors++; $display("FAIL write_master_cmd: got %h expected %h", {cap_rw, cap_addr, cap_data}, {1'b0, 7'h50, 8'hFE}); end
        checks++;
        if (en_cycles !== 5) begin errors++; $display("FAIL write_enable_len: got %0d expected 5", en_cycles); end
        repeat (3) @(negedge clock);
        checks++;
        if ({rsp_valid, m_enable, rsp_vec()} !== {1'b1, 1'b0, 1'b0, 7'h50, 8'h00, 1'b0, 1'b0})
            begin errors++; $display("FAIL write_rsp: got %h expected %h", {rsp_valid, m_enable, rsp_vec()}, {1'b1, 1'b0, 1'b0, 7'h50, 8'h00, 1'b0, 1'b0}); end
        ack_rsp();
    endtask

    task automatic test_read_gap();
        bit ok;
        int n;
        mode = 0; rx_byte = 8'hCC;
        push(1'b1, 7'h51, 8'h00, ok);
        wait_rsp(200, ok);
        checks++;
        if (!ok || rsp_vec() !== {1'b1, 7'h51, 8'hCC, 1'b0, 1'b0})
            begin errors++; $display("FAIL read_rsp: got %h expected %h", rsp_vec(), {1'b1, 7'h51, 8'hCC, 1'b0, 1'b0}); end
        checks++;
        if (cap_rw !== 1'b1) begin errors++; $display("FAIL read_m_rw: got %b expected 1", cap_rw); end
        push(1'b0, 7'h53, 8'h11, ok);
        @(negedge clock);
        rsp_ready = 1;
        @(posedge clock);
        #1 rsp_ready = 0;
        n = 0;
        while (!m_enable && n < 100) begin @(posedge clock); #1; n++; end
        checks++;
        if (n < IDLE_GAP + 1 || n >= 100)
            begin errors++; $display("FAIL idle_gap: got %0d expected >= %0d", n, IDLE_GAP + 1); end
        wait_rsp(100, ok);
        checks++;
        if (!ok || rsp_vec() !== {1'b0, 7'h53, 8'h00, 1'b0, 1'b0})
            begin errors++; $display("FAIL gap_next_rsp: got %h expected %h", rsp_vec(), {1'b0, 7'h53, 8'h00, 1'b0, 1'b0}); end
        ack_rsp();
    endtask

    task automatic test_fifo();
        bit ok;
        int acc = 0;
        int blocked = 0;
        logic [17:0] exp_r;
        wait_idle(ok);
        mode = 0; rx_byte = 8'h3C; rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            push(1'(i % 2), 7'(8'h10 + i), 8'(8'h20 + i), ok);
            if (ok) acc++;
        end
        checks++;
        if (acc !== 5) begin errors++; $display("FAIL fifo_accept: got %0d expected 5", acc); end
        @(negedge clock);
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL fifo_full: got %b expected 01", {cmd_ready, busy}); end
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h7F; cmd_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (cmd_ready) blocked++;
        end
        cmd_valid = 0;
        checks++;
        if (blocked !== 0) begin errors++; $display("FAIL fifo_block: got %0d ready cycles expected 0", blocked); end
        for (int i = 0; i < 5; i++) begin
            exp_r = {1'(i % 2), 7'(8'h10 + i), (i % 2) ? 8'h3C : 8'h00, 1'b0, 1'b0};
            wait_rsp(200, ok);
            checks++;
            if (!ok || rsp_vec() !== exp_r)
                begin errors++; $display("FAIL fifo_order_%0d: got %h expected %h", i, rsp_vec(), exp_r); end
            ack_rsp();
        end
        repeat (60) @(negedge clock);
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL fifo_extra: got %b expected 00", {rsp_valid, busy}); end
    endtask

    task automatic test_nack();
        bit ok;
        wait_idle(ok);
        mode = 1; en_cycles = 0;
        push(1'b0, 7'h52, 8'hAA, ok);
        wait_rsp(200, ok);
        checks++;
        if (!ok || rsp_vec() !== {1'b0, 7'h52, 8'h00, 1'b1, 1'b0})
            begin errors++; $display("FAIL nack_rsp: got %h expected %h", rsp_vec(), {1'b0, 7'h52, 8'h00, 1'b1, 1'b0}); end
        checks++;
        if (en_cycles !== 3) begin errors++; $display("FAIL nack_enable_len: got %0d expected 3", en_cycles); end
        ack_rsp();
        repeat (IDLE_GAP + 3) @(negedge clock);
        checks++;
        if ({busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL nack_idle: got %b expected 01", {busy, cmd_ready}); end
        mode = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        wait_idle(ok);
        mode = 2; en_cycles = 0;
        push(1'b1, 7'h55, 8'h00, ok);
        wait_rsp(TIMEOUT + 100, ok);
        checks++;
        if (!ok || rsp_vec() !== {1'b1, 7'h55, 8'h00, 1'b0, 1'b1})
            begin errors++; $display("FAIL timeout_rsp: got %h expected %h", rsp_vec(), {1'b1, 7'h55, 8'h00, 1'b0, 1'b1}); end
        checks++;
        if (m_enable !== 1'b0) begin errors++; $display("FAIL timeout_enable: got %b expected 0", m_enable); end
        checks++;
        if (en_cycles !== TIMEOUT - 1) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", en_cycles, TIMEOUT - 1); end
        ack_rsp();
        mode = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int seen_en = 0;
        logic [37:0] exp_v;
        exp_v = {1'b1, 37'd0};
        wait_idle(ok);
        mode = 0;
        push(1'b0, 7'h60, 8'h01, ok);
        push(1'b0, 7'h61, 8'h02, ok);
        push(1'b0, 7'h62, 8'h03, ok);
        while (!m_enable && n < 50) begin @(negedge clock); n++; end
        while (m_enable && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (n >= 100 || busy !== 1'b1) begin errors++; $display("FAIL mid_reach_wait: got n=%0d busy=%b expected wait_ready busy=1", n, busy); end
        #1 reset = 0;
        #1;
        checks++;
        if (out_vec() !== exp_v) begin errors++; $display("FAIL mid_reset_out: got %h expected %h", out_vec(), exp_v); end
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (m_enable || busy) seen_en++;
        end
        checks++;
        if ({seen_en != 0, busy, cmd_ready} !== 3'b001)
            begin errors++; $display("FAIL mid_queue_lost: got %0d active cycles busy=%b ready=%b expected 0 0 1", seen_en, busy, cmd_ready); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_gap();
        test_fifo();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
